// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALUOp codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// ALU control decoder shared with the single-cycle core: maps ALUOp and the
// R-type funct field onto the 3-bit ALUControl code.
import mips_ctrl_pkg::*;

module alu_decoder (
  input  logic [1:0] aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // The opcode is part of the legacy interface but does not affect the result.
  logic op_unused_s;
  assign op_unused_s = ^op;

  // ALUOp selects a fixed operation or defers to the funct field.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: one state per clock,
// Moore-style datapath controls, write strobes gated by memory readiness.
import mips_ctrl_pkg::*;

module mips_multicycle_controller #(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Illegal
);

  logic [3:0] state_r;
  logic [3:0] next_s;
  logic       ready_s;
  logic [1:0] aluop_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       illegal_s;

  assign ready_s = WAIT_MEM ? MemReady : 1'b1;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state selection.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_s = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_EXECUTE;
          OP_BEQ:       next_s = S_BRANCH;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JUMP;
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LW) begin
          next_s = S_MEMREAD;
        end else begin
          next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_s = ready_s ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_s = S_FETCH;
      S_MEMWRITE: next_s = ready_s ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_s = S_ALUWB;
      S_ALUWB:    next_s = S_FETCH;
      S_BRANCH:   next_s = S_FETCH;
      S_ADDIEX:   next_s = S_ADDIWB;
      S_ADDIWB:   next_s = S_FETCH;
      S_JUMP:     next_s = S_FETCH;
      default:    next_s = S_FETCH;
    endcase
  end

  // Per-state datapath controls; unused codes 12-15 drive everything low.
  always_comb begin
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSrc      = PCSRC_ALU;
    aluop_s    = ALUOP_ADD;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        irwrite_s = ready_s;
        pcwrite_s = ready_s;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (Opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_s = 1'b0;
          default:                                       illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop_s = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        aluop_s  = ALUOP_SUB;
        PCSrc    = PCSRC_ALUOUT;
        branch_s = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        PCSrc     = PCSRC_JUMP;
        pcwrite_s = 1'b1;
      end
      default: illegal_s = 1'b0;
    endcase
  end

  // Strobes are qualified by rst so none can be seen while reset is low.
  assign IRWrite  = rst & irwrite_s;
  assign MemWrite = rst & memwrite_s;
  assign RegWrite = rst & regwrite_s;
  assign Illegal  = rst & illegal_s;
  assign PCEn     = rst & (pcwrite_s | (branch_s & Zero));
  assign State    = state_r;

  alu_decoder u_alu_decoder (
    .aluop      (aluop_s),
    .op         (Opcode),
    .funct      (Funct),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for the multicycle controller: directed instruction
// sequences push hand-derived per-cycle expectations, a monitor compares.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn, Illegal;
  logic [2:0] ALUControl;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  mips_multicycle_controller #(.WAIT_MEM(1'b1)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
    .ALUControl(ALUControl), .State(State), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // Expected outputs {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  // ALUSrcB,PCSrc,PCEn,ALUControl,Illegal} for a given state and inputs.
  function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic r,
      input logic rdy, input logic z, input logic [5:0] op, input logic [5:0] fn);
    logic iord, mw, irw, rd, mtr, rw, sa, pen, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {iord, mw, irw, rd, mtr, rw, sa, pen, ill} = 9'd0;
    sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      4'd0: begin irw = r & rdy; pen = r & rdy; sb = 2'b01; end
      4'd1: begin
        sb = 2'b11;
        ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      4'd2: begin sa = 1'b1; sb = 2'b10; end
      4'd3: iord = 1'b1;
      4'd4: begin mtr = 1'b1; rw = 1'b1; end
      4'd5: begin iord = 1'b1; mw = 1'b1; end
      4'd6: begin
        sa = 1'b1;
        case (fn)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      4'd7: begin rd = 1'b1; rw = 1'b1; end
      4'd8: begin sa = 1'b1; ps = 2'b01; alu = 3'b110; pen = z; end
      4'd9: begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pen = 1'b1; end
      default: alu = 3'b010;
    endcase
    return {iord, mw, irw, rd, mtr, rw, sa, sb, ps, pen, alu, ill};
  endfunction

  // Drive one cycle's inputs and queue what the DUT should show in it.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
      input logic z, input logic rdy, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; Opcode = op; Funct = fn; Zero = z; MemReady = rdy;
    e.st = st;
    e.outs = exp_outs(st, r, rdy, z, op, fn);
    q.push_back(e);
  endtask

  // Monitor: compare the queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, PCEn, ALUControl, Illegal};
      checks++;
      if (State !== e.st || act !== e.outs) begin
        failures++;
        $display("FAIL cycle t=%0t state got=%0d want=%0d outs got=%b want=%b",
                 $time, State, e.st, act, e.outs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    // reset held three cycles
    repeat (3) step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    // lw: 0,1,2,3,4
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd3);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd4);
    // R-type with each funct: 0,1,6,7
    for (int i = 0; i < 5; i++) begin
      step(1'b1, RT, functs[i], 1'b0, 1'b1, 4'd0);
      step(1'b1, RT, functs[i], 1'b0, 1'b1, 4'd1);
      step(1'b1, RT, functs[i], 1'b0, 1'b1, 4'd6);
      step(1'b1, RT, functs[i], 1'b0, 1'b1, 4'd7);
    end
    // beq taken then not taken
    for (int i = 0; i < 2; i++) begin
      step(1'b1, BEQ, 6'd0, i == 0, 1'b1, 4'd0);
      step(1'b1, BEQ, 6'd0, i == 0, 1'b1, 4'd1);
      step(1'b1, BEQ, 6'd0, i == 0, 1'b1, 4'd8);
    end
    // sw with two wait cycles in MEMWRITE
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd5);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd5);
    // illegal opcode, with a fetch wait first
    step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, 6'b111111, 6'd0, 1'b0, 1'b1, 4'd1);
    // addi then j
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd9);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd10);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd11);
    // lw with a read wait, then asynchronous reset during MEMWB
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd2);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd3);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd3);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd4);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL async_reset state got=%0d want=0 regwrite got=%b want=0 memwrite got=%b want=0",
               State, RegWrite, MemWrite);
    end
    step(1'b0, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain queue got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
